// File: rtl/ucq_pkg.sv
// Shared literal type and helpers for the multi-port unit clause queue.
// A literal is a two's-complement signed value; zero means "no literal".
package ucq_pkg;

  localparam int unsigned LIT_W = 10;

  typedef logic signed [LIT_W-1:0] lit_t;

  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

endpackage

// File: rtl/ucq_multi_if.sv
// Producer/consumer handshake bundle for ucq_multi.
// The master side drives literals and out_ready. The slave side is the queue.
interface ucq_multi_if #(
  parameter int unsigned NUM_PUSH = 2,
  parameter int unsigned LIT_W    = ucq_pkg::LIT_W
);

  logic [NUM_PUSH-1:0]            in_valid;
  logic [NUM_PUSH-1:0][LIT_W-1:0] in_lit;
  logic                           in_ready;
  logic                           out_valid;
  logic [LIT_W-1:0]               out_lit;
  logic                           out_ready;

  modport master (
    output in_valid, in_lit, out_ready,
    input  in_ready, out_valid, out_lit
  );

  modport slave (
    input  in_valid, in_lit, out_ready,
    output in_ready, out_valid, out_lit
  );

endinterface

// File: rtl/ucq_lit_match.sv
// Compares one candidate literal against every valid queue entry.
// It reports an exact match (duplicate) and a complementary match (conflict).
module ucq_lit_match
  import ucq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  lit_t             cand,
  input  lit_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0] entry_valid,
  output logic             dup_hit,
  output logic             neg_hit
);

  lit_t cand_neg;

  assign cand_neg = lit_neg(cand);

  always_comb begin
    dup_hit = 1'b0;
    neg_hit = 1'b0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (entry_valid[j] && (entries[j] == cand))
        dup_hit = 1'b1;
      if (entry_valid[j] && (entries[j] == cand_neg))
        neg_hit = 1'b1;
    end
  end

endmodule

// File: rtl/ucq_multi.sv
// Multi-port unit clause queue. It accepts up to NUM_PUSH literals per cycle.
// It drops duplicates, flags complementary pairs, and presents one literal per cycle.
module ucq_multi
  import ucq_pkg::*;
#(
  parameter int unsigned LIT_W    = ucq_pkg::LIT_W,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_PUSH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   clr_status,
  ucq_multi_if.slave             bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   conflict,
  output logic [LIT_W-1:0]       conflict_lit,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t             head_q, tail_q;
  lit_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0] entry_valid;

  logic             conflict_q, conflict_n;
  lit_t             conflict_lit_q, conflict_lit_n;
  logic             overflow_q, overflow_n;

  lit_t [NUM_PUSH-1:0]          cand;
  logic [NUM_PUSH-1:0]          dup_hit, neg_hit;
  logic [NUM_PUSH-1:0]          acc;
  logic [NUM_PUSH-1:0][AW-1:0]  wr_idx;
  ptr_t                         acc_cnt;
  logic                         intra_dup, intra_neg;
  logic                         new_conf;
  lit_t                         new_conf_lit;
  logic                         overflow_set;
  logic                         pop;

  assign count         = tail_q - head_q;
  assign bus.in_ready  = (DEPTH - 32'(count)) >= NUM_PUSH;
  assign bus.out_valid = (head_q != tail_q);
  assign bus.out_lit   = bus.out_valid ? mem_q[head_q[AW-1:0]] : '0;
  assign pop           = bus.out_valid && bus.out_ready;

  assign conflict      = conflict_q;
  assign conflict_lit  = conflict_lit_q;
  assign overflow      = overflow_q;

  // An entry is live when its distance from head is below the occupancy.
  // The head stays live during its own pop, so that a re-push of it is still caught as a duplicate.
  always_comb begin
    entry_valid = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      entry_valid[j] = ptr_t'(AW'(j) - head_q[AW-1:0]) < count;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PUSH; gi++) begin : g_match
      assign cand[gi] = lit_t'(bus.in_lit[gi]);
      ucq_lit_match #(
        .DEPTH (DEPTH)
      ) u_match (
        .cand        (cand[gi]),
        .entries     (mem_q),
        .entry_valid (entry_valid),
        .dup_hit     (dup_hit[gi]),
        .neg_hit     (neg_hit[gi])
      );
    end
  endgenerate

  // Ports are resolved in ascending order.
  // Each candidate is also checked against the ports already accepted in this cycle.
  always_comb begin
    acc          = '0;
    wr_idx       = '0;
    acc_cnt      = '0;
    intra_dup    = 1'b0;
    intra_neg    = 1'b0;
    new_conf     = 1'b0;
    new_conf_lit = '0;
    overflow_set = 1'b0;
    if (!bus.in_ready) begin
      overflow_set = |bus.in_valid;
    end else begin
      for (int unsigned i = 0; i < NUM_PUSH; i++) begin
        if (bus.in_valid[i] && (cand[i] != '0)) begin
          intra_dup = 1'b0;
          intra_neg = 1'b0;
          for (int unsigned k = 0; k < i; k++) begin
            if (acc[k] && (cand[k] == cand[i]))
              intra_dup = 1'b1;
            if (acc[k] && (cand[k] == lit_neg(cand[i])))
              intra_neg = 1'b1;
          end
          if (neg_hit[i] || intra_neg) begin
            if (!new_conf)
              new_conf_lit = cand[i];
            new_conf = 1'b1;
          end
          if (!(dup_hit[i] || intra_dup)) begin
            acc[i]    = 1'b1;
            wr_idx[i] = AW'(tail_q + acc_cnt);
            acc_cnt   = acc_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Clearing comes first, so a conflict or overflow raised in the same cycle still sets the flag.
  always_comb begin
    conflict_n     = conflict_q;
    conflict_lit_n = conflict_lit_q;
    overflow_n     = overflow_q;
    if (clr_status) begin
      conflict_n     = 1'b0;
      conflict_lit_n = '0;
      overflow_n     = 1'b0;
    end
    if (!flush && new_conf) begin
      if (!conflict_q || clr_status)
        conflict_lit_n = new_conf_lit;
      conflict_n = 1'b1;
    end
    if (!flush && overflow_set)
      overflow_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      tail_q <= tail_q + acc_cnt;
      if (pop)
        head_q <= head_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int unsigned i = 0; i < NUM_PUSH; i++) begin
        if (acc[i])
          mem_q[wr_idx[i]] <= cand[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      conflict_q     <= conflict_n;
      conflict_lit_q <= conflict_lit_n;
      overflow_q     <= overflow_n;
    end
  end

endmodule

// File: tb/tb_ucq_multi.sv
// Directed bench for ucq_multi with DEPTH=8, NUM_PUSH=2, LIT_W=10.
// Expected values are worked out by hand from the queue contents at each step.
module tb_ucq_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       clr_status;
  logic [3:0] count;
  logic       conflict;
  logic [9:0] conflict_lit;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  ucq_multi_if #(.NUM_PUSH(2), .LIT_W(10)) bus ();

  ucq_multi #(
    .LIT_W    (10),
    .DEPTH    (8),
    .NUM_PUSH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .clr_status   (clr_status),
    .bus          (bus),
    .count        (count),
    .conflict     (conflict),
    .conflict_lit (conflict_lit),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lv(input int v);
    logic [9:0] t;
    t = 10'(v);
    return {22'b0, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int cnt, input logic ov, input int lit);
    chk({tag, ".count"}, {28'b0, count}, lv(cnt));
    chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, ov});
    if (ov)
      chk({tag, ".out_lit"}, {22'b0, bus.out_lit}, lv(lit));
  endtask

  task automatic drive(input logic v0, input int l0, input logic v1, input int l1,
                       input logic pop, input logic fl, input logic clr);
    bus.in_valid  = {v1, v0};
    bus.in_lit[0] = 10'(l0);
    bus.in_lit[1] = 10'(l1);
    bus.out_ready = pop;
    flush         = fl;
    clr_status    = clr;
    @(posedge clk);
    #1;
    bus.in_valid  = '0;
    bus.in_lit    = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    clr_status    = 1'b0;
  endtask

  int drain_exp [6] = '{6, 7, 12, 13, 14, 15};

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    clr_status    = 1'b0;
    bus.in_valid  = '0;
    bus.in_lit    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", {28'b0, count}, 32'd0);
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.out_lit", {22'b0, bus.out_lit}, 32'd0);
    chk("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst.conflict", {31'b0, conflict}, 32'd0);
    chk("rst.conflict_lit", {22'b0, conflict_lit}, 32'd0);
    chk("rst.overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    // Basic FIFO order and first-word fall-through
    drive(1, 3, 0, 0, 0, 0, 0);  chk_q("fifo.push3", 1, 1, 3);
    drive(1, -5, 0, 0, 0, 0, 0); chk_q("fifo.push-5", 2, 1, 3);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("fifo.pop1", 1, 1, -5);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("fifo.pop2", 0, 0, 0);

    // Duplicate suppression against storage and within the cycle
    drive(1, 4, 0, 0, 0, 0, 0);  chk_q("dup.push4", 1, 1, 4);
    drive(1, 4, 1, 7, 0, 0, 0);  chk_q("dup.push4_7", 2, 1, 4);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("dup.pop4", 1, 1, 7);
    drive(1, 9, 1, 9, 0, 0, 0);  chk_q("dup.push9_9", 2, 1, 7);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("dup.pop7", 1, 1, 9);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("dup.pop9", 0, 0, 0);
    chk("dup.conflict", {31'b0, conflict}, 32'd0);

    // Conflict detection, sticky capture, clear
    drive(1, 6, 0, 0, 0, 0, 0);  chk_q("conf.push6", 1, 1, 6);
    drive(0, 0, 1, -6, 0, 0, 0); chk_q("conf.push-6", 2, 1, 6);
    chk("conf.flag", {31'b0, conflict}, 32'd1);
    chk("conf.lit", {22'b0, conflict_lit}, lv(-6));
    drive(1, 2, 1, -2, 0, 0, 0); chk_q("conf.push2_-2", 4, 1, 6);
    chk("conf.lit_kept", {22'b0, conflict_lit}, lv(-6));
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("conf.clr_flag", {31'b0, conflict}, 32'd0);
    chk("conf.clr_lit", {22'b0, conflict_lit}, 32'd0);
    drive(0, 0, 0, 0, 0, 1, 0);  chk_q("conf.flush", 0, 0, 0);

    // Fill, overflow, wrap, and simultaneous push and pop
    drive(1, 1, 1, 2, 0, 0, 0);
    drive(1, 3, 1, 4, 0, 0, 0);
    drive(1, 5, 1, 6, 0, 0, 0);  chk_q("full.fill6", 6, 1, 1);
    chk("full.ready6", {31'b0, bus.in_ready}, 32'd1);
    drive(1, 7, 0, 0, 0, 0, 0);  chk_q("full.fill7", 7, 1, 1);
    chk("full.ready7", {31'b0, bus.in_ready}, 32'd0);
    drive(1, 11, 0, 0, 0, 0, 0); chk_q("full.ovf_push", 7, 1, 1);
    chk("full.overflow", {31'b0, overflow}, 32'd1);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("full.pop_a", 6, 1, 2);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("full.pop_b", 5, 1, 3);
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("full.pop_c", 4, 1, 4);
    chk("full.ready4", {31'b0, bus.in_ready}, 32'd1);
    drive(1, 12, 1, 13, 0, 0, 0); chk_q("wrap.push12_13", 6, 1, 4);
    drive(1, 14, 1, 15, 1, 0, 0); chk_q("wrap.pushpop", 7, 1, 5);
    chk("wrap.ready", {31'b0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk_q($sformatf("wrap.drain%0d", i), 6 - i, 1, drain_exp[i]);
    end
    drive(0, 0, 0, 0, 1, 0, 0);  chk_q("wrap.empty", 0, 0, 0);

    // Flush keeps status; reset clears everything
    drive(1, 20, 1, 21, 0, 0, 0);
    drive(1, 22, 1, -20, 0, 0, 0);
    chk("fl.conflict", {31'b0, conflict}, 32'd1);
    chk("fl.conflict_lit", {22'b0, conflict_lit}, lv(-20));
    drive(1, 23, 0, 0, 0, 0, 0); chk_q("fl.count5", 5, 1, 20);
    drive(1, 30, 0, 0, 1, 1, 0); chk_q("fl.flushed", 0, 0, 0);
    chk("fl.conflict_kept", {31'b0, conflict}, 32'd1);
    chk("fl.overflow_kept", {31'b0, overflow}, 32'd1);
    drive(1, 40, 0, 0, 0, 0, 0); chk_q("fl.push40", 1, 1, 40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2.count", {28'b0, count}, 32'd0);
    chk("rst2.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst2.out_lit", {22'b0, bus.out_lit}, 32'd0);
    chk("rst2.in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst2.conflict", {31'b0, conflict}, 32'd0);
    chk("rst2.conflict_lit", {22'b0, conflict_lit}, 32'd0);
    chk("rst2.overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucq_multi.md
Name: ucq_multi

Overview:
- Multi-port unit clause queue: collects unit literals from up to NUM_PUSH process engines per cycle and feeds the unit clause arbiter one literal per cycle.
- Adds several features a single-port FIFO does not have:
  - valid/ready handshakes on both sides
  - duplicate-literal suppression
  - conflict detection (a literal and its negation both pending)
  - sticky overflow/conflict status
  - flush
- Sits between the engines' unit outputs and the arbiter; one instance per lookup cluster.

Parameters:
- LIT_W, 10, width of a signed literal (two's complement; 0 = no literal)
- DEPTH, 8, queue entries; must be a power of 2, >= 2
- NUM_PUSH, 2, producer ports sampled per cycle; 1..4

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  drop all entries next cycle; status flags unaffected
- clr_status  in  1  clear conflict and overflow flags
- in_valid  in  NUM_PUSH  per-port literal valid
- in_lit  in  NUM_PUSH x LIT_W  per-port signed literal
- in_ready  out  1  all ports may push this cycle
- out_valid  out  1  head entry present
- out_lit  out  LIT_W  head literal (first-word fall-through)
- out_ready  in  1  consumer takes head
- count  out  $clog2(DEPTH)+1  occupied entries
- conflict  out  1  sticky: complementary literals seen
- conflict_lit  out  LIT_W  incoming literal that caused the first conflict
- overflow  out  1  sticky: push attempted while in_ready=0

Behaviour:
- Reset: all of the following clear and stay cleared for the reset cycle:
  - head, tail, count = 0
  - out_valid = 0, out_lit = 0
  - conflict = 0, conflict_lit = 0, overflow = 0
  - in_ready = 1
- Storage: circular buffer; head/tail pointers of $clog2(DEPTH)+1 bits, wrap-bit scheme.
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
- in_ready = (DEPTH - count) >= NUM_PUSH, computed from registered count only. A same-cycle pop does not raise in_ready.
- Push acceptance: when in_ready=1, each port i with in_valid[i]=1 and in_lit[i] != 0 is a candidate, evaluated in ascending port order.
  - A candidate is dropped as a duplicate if it equals any valid stored entry (including a head popped this cycle) or an earlier accepted port this cycle.
  - Accepted literals are written at tail, tail+1, ... in port order. Tail advances by the accepted count, with wrap.
- Conflict: a candidate equal to the negation of any valid stored entry, or of an earlier accepted port's literal, sets conflict=1 next cycle.
  - conflict_lit captures that candidate only if conflict was 0; the lowest port wins.
  - The conflicting literal is still enqueued.
- Overflow: any in_valid[i]=1 while in_ready=0 sets overflow=1. All port literals are discarded that cycle.
- Pop: when out_valid and out_ready are both 1, head advances by 1. out_lit/out_valid reflect the new head next cycle.
- Simultaneous push and pop: both take effect; count_next = count + accepted - popped.
- Flush: next cycle head = tail = count = 0. Pushes and pops in the flush cycle are ignored. conflict/overflow are retained.
- clr_status: clears conflict, conflict_lit and overflow next cycle. If a new conflict or overflow occurs in the same cycle, the set wins.
- Priority: rst > flush > normal operation.
- Reset mid-operation discards all contents; no output pulses.
- Latency: a pushed literal is visible on out_lit in the cycle after acceptance when the queue was empty.

Decomposition:
- Package ucq_pkg holds:
  - LIT_W default constant
  - typedef lit_t (signed logic [LIT_W-1:0])
  - function lit_neg
- Sub-module ucq_lit_match: compares one candidate against DEPTH entries plus a valid mask.
  - Returns dup_hit and neg_hit.
  - Instantiated NUM_PUSH times.
  - Intra-cycle checks are done in the parent.

Test Plan:
- Basic FIFO, NUM_PUSH=2, DEPTH=8:
  - push port0=3 in cycle 1, then push -5 in cycle 2, then pop twice.
  - Required: out_lit 3 then -5; count goes 1, 2, 1, 0; out_valid falls after the last pop.
- Duplicate suppression:
  - queue holds 4; push port0=4, port1=7 in one cycle.
  - Required: only 7 enqueued, count=2.
  - Then push both ports = 9: only one 9 enqueued.
- Conflict:
  - queue holds 6; push port1=-6.
  - Required: conflict=1 next cycle, conflict_lit=-6, count=2.
  - A later push of 2/-2 leaves conflict_lit at -6.
  - clr_status clears conflict to 0.
- Full/overflow with wrap:
  - fill to count=7; in_ready=0.
  - Push 11: overflow=1, count unchanged.
  - Pop 3 entries and push 2 per cycle around the pointer wrap; output order is preserved across wrap.
- Simultaneous push/pop at count=6: pop head while pushing 2 literals. Required: count=7 and in_ready=0 next cycle.
- Flush and reset mid-stream:
  - with count=5 and conflict=1, assert flush. Required: count=0, out_valid=0, conflict still 1.
  - Then rst: all outputs 0.
